// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell reused across WIDTH
// steps, LSB first, with registered sum/cout/ovf and a one-cycle done pulse.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only in IDLE; an accepted start launches one
  // operation, busy is high during the WIDTH ADD cycles, and done pulses for
  // exactly one cycle when sum/cout/ovf first show the new result. No queueing.

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic             msb_cin;
  logic [CW-1:0]    cnt;

  logic             bit_sum;
  logic             bit_carry;
  logic [WIDTH-1:0] sum_nx;

  always_comb begin
    bit_sum   = a_sr[0] ^ b_sr[0] ^ carry;
    bit_carry = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    sum_nx    = sum_sr >> 1;
    sum_nx[WIDTH-1] = bit_sum;
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry   <= 1'b0;
      msb_cin <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= sub ? ~b : b;
            carry  <= sub ? 1'b1 : cin;
            cnt    <= '0;
            sum_sr <= '0;
            busy   <= 1'b1;
            state  <= ADD;
          end
        end
        ADD: begin
          sum_sr <= sum_nx;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= bit_carry;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            // carry entering the MSB cell is the pre-update carry of this step
            msb_cin <= carry;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          sum   <= sum_sr;
          cout  <= carry;
          ovf   <= msb_cin ^ carry;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add/subtract controller that time-shares a single one-bit full-adder cell across a WIDTH-bit operand pair, one bit per clock, LSB first. It latches operands on a start handshake and sequences the cell through WIDTH steps while holding the running carry. It then presents sum, carry-out and signed overflow with a one-cycle done pulse. It is the area-minimal alternative to a ripple array of full-adder cells in the arithmetic datapath.

## Interface
- WIDTH, default 8: operand width in bits; legal range WIDTH >= 1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0 = a+b+cin, 1 = a-b (a + ~b + 1; cin ignored).
- a  in  WIDTH  operand A, latched on accepted start.
- b  in  WIDTH  operand B, latched on accepted start.
- cin  in  1  carry-in, latched on accepted start.
- busy  out  1  high while in ADD state.
- done  out  1  one-cycle pulse, result valid.
- sum  out  WIDTH  result.
- cout  out  1  carry-out (for sub: 1 = no borrow).
- ovf  out  1  signed overflow (carry into MSB XOR carry out of MSB).

## Operation
- States: IDLE, ADD, DONE. Reset state IDLE.
- IDLE: on start=1, load the A shift register with a and the B shift register with sub ? ~b : b. Load the carry register with sub ? 1 : cin. Clear the bit counter, clear the internal sum shift register, go to ADD. Otherwise stay.
- ADD, each cycle:
  - full-add of A[0], B[0] and the carry register.
  - Shift the sum bit into the MSB of the internal sum register (shift right).
  - Shift A and B right, update the carry register, increment the counter.
  - On the step with counter = WIDTH-1, also capture the carry into the MSB (the carry register before update) for ovf, then go to DONE.
- DONE: copy the internal sum, final carry and ovf to the output registers; assert done; go to IDLE unconditionally.
- The outputs sum, cout and ovf are registers. They hold the previous result throughout ADD and update only on the DONE transition. They stay stable until the next completion.
- start is ignored in ADD and DONE. A request is never queued.
- The counter is max(1, $clog2(WIDTH+1)) bits wide. There is no wrap inside an operation.
- WIDTH=1: ADD lasts one cycle. ovf = cin_to_msb ^ cout, where cin_to_msb is the initial carry.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, all internal registers cleared. Takes effect immediately, including mid-operation. An aborted operation produces no done and no partial result.
- Let start be accepted at rising edge E0.
  - busy=1 in the cycles after edges E0 .. E0+WIDTH-1.
  - State is DONE after edge E0+WIDTH. done=1 and sum/cout/ovf take the new values after edge E0+WIDTH+1.
  - The first cycle of the done pulse is the first cycle in which the new result is visible.
- Latency from start edge to done high: WIDTH+1 edges. Throughput: one operation per WIDTH+2 cycles.
- The earliest next accepted start is the edge after the done pulse, because IDLE is re-entered at that edge.
- busy and done are registered and are never high together.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, sub=0, start pulse -> sum=0x96, cout=0, ovf=1. done is high exactly 9 edges after the start edge. busy is high for 8 cycles.
- WIDTH=8, a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- WIDTH=8, sub=1:
  - a=0x10, b=0x20 -> sum=0xF0, cout=0, ovf=0.
  - a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
  - cin=1 in both cases has no effect.
- WIDTH=8, start held high continuously with operands changed mid-operation:
  - Each operation uses the operands latched at acceptance.
  - Accepts occur every 10 edges.
  - sum is unchanged during ADD.
- WIDTH=8, rst_n pulled low after the 4th ADD edge:
  - busy, done, sum, cout and ovf go to 0 without waiting for a clock.
  - No done pulse follows.
  - After release, a new start 0x01+0x01 gives sum=0x02.
- WIDTH=1, exhaustive over all 16 combinations of {a, b, cin, sub} -> {cout, sum} equals a+b+cin (sub=0) or a+~b+1 (sub=1). ovf matches the reference formula. done latency is 2 edges.
